// File: rtl/ps2_mouse_sequencer_if.sv
// Command/receive handshake between the mouse sequencer and the PS/2 transceiver.
interface ps2_mouse_sequencer_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output the_command, send_command,
    input  command_was_sent, error_communication_timed_out, received_data, received_data_en
  );
  modport slave (
    input  the_command, send_command,
    output command_was_sent, error_communication_timed_out, received_data, received_data_en
  );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up (reset, sample rate, enable) followed by 3-byte stream packet
// decode, with a single host-issued command slot while streaming.
module ps2_mouse_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 5_000_000,
  parameter int unsigned RESP_TIMEOUT   = 1_250_000,
  parameter int unsigned BAT_TIMEOUT    = 50_000_000,
  parameter int unsigned BYTE_GAP       = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  ps2_mouse_sequencer_if.master        xcvr,
  input  logic                         host_cmd_req,
  input  logic [7:0]                   host_cmd_byte,
  output logic                         host_cmd_done,
  output logic                         host_cmd_ok,
  output logic                         mouse_ready,
  output logic                         init_error,
  output logic [8:0]                   dx,
  output logic [8:0]                   dy,
  output logic [2:0]                   buttons,
  output logic                         x_ovf,
  output logic                         y_ovf,
  output logic                         packet_valid
);
  typedef enum logic [3:0] {
    S_POWERUP, S_SEND, S_GAP, S_WAIT_ACK, S_WAIT_BAT,
    S_STREAM, S_HOST_SEND, S_HOST_WAIT, S_ERROR
  } state_e;

  localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

  state_e      state_q;
  logic [31:0] tmr_q;
  logic [7:0]  retry_q, cmd_q, b0_q, b1_q;
  logic [1:0]  step_q, idx_q;
  logic        bat_aa_q, armed_q, send_q, done_q, ok_q, ready_q, err_q, pv_q, xo_q, yo_q;
  logic [8:0]  dx_q, dy_q;
  logic [2:0]  btn_q;
  logic [7:0]  init_byte;

  wire       rx_en = xcvr.received_data_en;
  wire [7:0] rx    = xcvr.received_data;

  always_comb begin
    case (step_q)
      2'd0:    init_byte = 8'hFF;
      2'd1:    init_byte = 8'hF3;
      2'd2:    init_byte = SAMPLE_RATE;
      default: init_byte = 8'hF4;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_POWERUP; tmr_q <= '0; retry_q <= '0; cmd_q <= '0;
      b0_q <= '0; b1_q <= '0; step_q <= '0; idx_q <= '0; bat_aa_q <= 1'b0;
      armed_q <= 1'b0; send_q <= 1'b0; done_q <= 1'b0; ok_q <= 1'b0;
      ready_q <= 1'b0; err_q <= 1'b0; pv_q <= 1'b0; xo_q <= 1'b0; yo_q <= 1'b0;
      dx_q <= '0; dy_q <= '0; btn_q <= '0;
    end else begin
      done_q <= 1'b0;
      pv_q   <= 1'b0;
      tmr_q  <= tmr_q + 32'd1;
      if (!host_cmd_req) armed_q <= 1'b1;
      case (state_q)
        S_POWERUP:
          if (tmr_q == POWERUP_CYCLES) begin state_q <= S_SEND; tmr_q <= '0; end
        S_SEND:
          // Byte is latched with the request so it cannot move while send is high.
          if (!send_q) begin
            send_q <= 1'b1; cmd_q <= init_byte;
          end else if (xcvr.command_was_sent) begin
            send_q <= 1'b0; state_q <= S_WAIT_ACK; tmr_q <= '0;
          end else if (xcvr.error_communication_timed_out) begin
            send_q <= 1'b0; retry_q <= retry_q + 8'd1; state_q <= S_GAP;
          end
        S_GAP: begin
          tmr_q   <= '0;
          state_q <= (retry_q >= MAX_R) ? S_ERROR : S_SEND;
          err_q   <= (retry_q >= MAX_R);
        end
        S_WAIT_ACK:
          if (rx_en && rx == 8'hFA) begin
            retry_q <= '0; tmr_q <= '0;
            case (step_q)
              2'd0:    begin state_q <= S_WAIT_BAT; bat_aa_q <= 1'b0; end
              2'd3:    begin state_q <= S_STREAM; ready_q <= 1'b1; idx_q <= '0; end
              default: begin step_q <= step_q + 2'd1; state_q <= S_SEND; end
            endcase
          end else if ((rx_en && rx == 8'hFE) || tmr_q == RESP_TIMEOUT) begin
            retry_q <= retry_q + 8'd1; state_q <= S_GAP;
          end
        S_WAIT_BAT:
          if (rx_en && rx == 8'hAA) begin
            bat_aa_q <= 1'b1;
          end else if (rx_en && bat_aa_q && rx == 8'h00) begin
            step_q <= 2'd1; state_q <= S_SEND; tmr_q <= '0;
          end else if ((rx_en && rx == 8'hFC) || tmr_q == BAT_TIMEOUT) begin
            step_q <= 2'd0; retry_q <= retry_q + 8'd1; state_q <= S_GAP;
          end
        S_STREAM:
          if (rx_en) begin
            tmr_q <= '0;
            case (idx_q)
              2'd0: if (rx[3]) begin b0_q <= rx; idx_q <= 2'd1; end
              2'd1: begin b1_q <= rx; idx_q <= 2'd2; end
              default: begin
                dx_q <= {b0_q[4], b1_q}; dy_q <= {b0_q[5], rx};
                btn_q <= b0_q[2:0]; xo_q <= b0_q[6]; yo_q <= b0_q[7];
                pv_q <= 1'b1; idx_q <= 2'd0;
              end
            endcase
          end else if (idx_q == 2'd0 && host_cmd_req && armed_q) begin
            armed_q <= 1'b0; state_q <= S_HOST_SEND; tmr_q <= '0;
          end else if (tmr_q == BYTE_GAP) begin
            // Saturate so an idle link never wraps the gap timer.
            tmr_q <= tmr_q; idx_q <= 2'd0;
          end
        S_HOST_SEND:
          if (!send_q) begin
            send_q <= 1'b1; cmd_q <= host_cmd_byte;
          end else if (xcvr.command_was_sent) begin
            send_q <= 1'b0; state_q <= S_HOST_WAIT; tmr_q <= '0;
          end else if (xcvr.error_communication_timed_out) begin
            send_q <= 1'b0; done_q <= 1'b1; ok_q <= 1'b0;
            state_q <= S_STREAM; idx_q <= '0; tmr_q <= '0;
          end
        S_HOST_WAIT:
          // Host commands are not retried; any failure is reported through ok=0.
          if (rx_en && rx == 8'hFA) begin
            done_q <= 1'b1; ok_q <= 1'b1; state_q <= S_STREAM; idx_q <= '0; tmr_q <= '0;
          end else if ((rx_en && rx == 8'hFE) || tmr_q == RESP_TIMEOUT) begin
            done_q <= 1'b1; ok_q <= 1'b0; state_q <= S_STREAM; idx_q <= '0; tmr_q <= '0;
          end
        S_ERROR:  tmr_q <= tmr_q;
        default:  state_q <= S_ERROR;
      endcase
    end
  end

  assign xcvr.the_command  = cmd_q;
  assign xcvr.send_command = send_q;
  assign host_cmd_done     = done_q;
  assign host_cmd_ok       = ok_q;
  assign mouse_ready       = ready_q;
  assign init_error        = err_q;
  assign dx                = dx_q;
  assign dy                = dy_q;
  assign buttons           = btn_q;
  assign x_ovf             = xo_q;
  assign y_ovf             = yo_q;
  assign packet_valid      = pv_q;
endmodule
